ita_requant_stage: RTL and testbench
====================================

// Module: ita_requant_stage
// PURPOSE
//  Elastic 2-stage requantiser between the accumulator (oup_t, N x WO signed) and the output FIFO (N x WI).
//  - Per lane: multiply by eps_mult, round-shift, add offset, clip to 8 bit.
//  - Constant set chosen per beat from the beat's step_e tag.
//  - Valid/ready on both sides; full throughput; order preserved.
// PARAMETERS
//  N     16  lanes per beat (ita_package::N)
//  WO    26  accumulator lane width, signed
//  WI     8  output lane width
//  EMS    8  eps_mult / right_shift width, unsigned
//  NCONST 6  requant constant sets (ita_package::N_REQUANT_CONSTS)
// PORTS
//  clk_i        in   1                  clock
//  rst_ni       in   1                  async reset, active low
//  flush_i      in   1                  sync clear of all in-flight beats
//  mode_i       in   requant_mode_e     Signed: clip [-128,127]; Unsigned: clip [0,255]
//  eps_mult_i   in   NCONST*EMS         requant_const_array_t, quasi-static
//  right_shift_i in  NCONST*EMS         requant_const_array_t, quasi-static
//  add_i        in   NCONST*WI          requant_array_t, signed, quasi-static
//  in_valid_i   in   1                  beat valid
//  in_ready_o   out  1                  beat accepted when valid&ready
//  in_data_i    in   N*WO               oup_t
//  in_step_i    in   step_e             step tag of the beat
//  out_valid_o  out  1                  result valid
//  out_ready_i  in   1                  downstream ready
//  out_data_o   out  N*WI               requant_oup_t
//  busy_o       out  1                  any stage holds a beat
//  err_o        out  1                  sticky: Idle-tagged beat seen
// BEHAVIOUR
//  - Reset (async, rst_ni=0): all valids 0, out_data_o 0, err_o 0, busy_o 0, in_ready_o 1 after release.
//  - Index: Q..OW -> step-1 (0..5); FF -> 0.
//  - Idle-tagged beat: accepted, dropped, err_o set (cleared only by reset).
//  - S1, on accept: prod = in * zext(eps_mult[idx]), 35-bit signed.
//    Registered with right_shift[idx] and add[idx]; constants latched with the beat.
//  - S2: r = (sh==0) ? prod : (prod + (1<<(sh-1))) >>> sh   (round half up, arithmetic shift).
//    v = r + sext(add); clip per mode_i; registered into out_data_o.
//  - Shift >= 35 yields 0 or -1 before rounding per sign. No intermediate overflow: use 36-bit sums.
//  - Latency: accept at cycle t -> out_valid_o at t+2 when unstalled. One beat per cycle sustained.
//  - Stall rules:
//    - Stage advances when its successor is empty or advancing.
//    - in_ready_o = !s1_v | !s2_v | out_ready_i.
//    - With out_valid_o=1 and out_ready_i=0: out_data_o stable, max 2 beats held.
//  - flush_i: next edge clears s1_v, s2_v; in_ready_o forced 0 that cycle. A beat offered that cycle is not accepted.
//  - flush_i & accept: flush wins.
//  - Constants may change only when busy_o=0; in-flight beats use latched values.
//  - busy_o = s1_v | s2_v.
// STRUCTURE
//  - ita_package already owns: oup_t, requant_oup_t, requant_const_array_t, requant_array_t, step_e, requant_mode_e.
//  - Add to ita_package: localparam RequantProdWidth = WO+EMS+1.
//  - Sub-module ita_requant_lane: combinational shift/round/add/clip for one lane, instanced N times in S2.
//  - Top holds S1/S2 regs, handshake, constant select.
// TESTING
//  1. Signed Q beat, lane=100, eps=3, sh=2, add=5 -> 80 at t+2.
//     lane=-100, same constants -> -70.
//  2. Same beats, mode Unsigned -> 80 and 0. Lane=2^25-1, eps=255, sh=0 -> 127 Signed, 255 Unsigned.
//  3. Steps Q,K,V,QK,AV,OW,FF back-to-back, distinct add per set -> each output uses its set, FF uses set 0.
//     One result per cycle.
//  4. 4 beats, out_ready_i=0 for 5 cycles -> in_ready_o low after 2 accepts; outputs in order, data stable while stalled.
//  5. Idle-tagged beat -> no output, err_o=1. flush_i with 2 in flight -> busy_o=0 next cycle, no outputs.
//  6. rst_ni low mid-stream -> out_valid_o=0 immediately. After release, first beat completes at t+2.

Source files
------------

// File: rtl/ita_requant_stage_pkg.sv
// Shared types, widths and helpers for the requantisation stage.
// Stands in for the ita_package types that this block consumes.
package ita_requant_stage_pkg;

    localparam int unsigned N                = 16;
    localparam int unsigned WO               = 26;
    localparam int unsigned WI               = 8;
    localparam int unsigned EMS              = 8;
    localparam int unsigned NCONST           = 6;
    localparam int unsigned RequantProdWidth = WO + EMS + 1;
    // One extra bit so rounding bias and offset additions never overflow.
    localparam int unsigned RequantSumWidth  = RequantProdWidth + 1;
    localparam int unsigned ConstIdxWidth    = $clog2(NCONST);

    typedef enum logic [2:0] {
        Idle = 3'd0,
        Q    = 3'd1,
        K    = 3'd2,
        V    = 3'd3,
        QK   = 3'd4,
        AV   = 3'd5,
        OW   = 3'd6,
        FF   = 3'd7
    } step_e;

    typedef enum logic {
        Signed   = 1'b0,
        Unsigned = 1'b1
    } requant_mode_e;

    typedef logic [N-1:0][WO-1:0]         oup_t;
    typedef logic [N-1:0][WI-1:0]         requant_oup_t;
    typedef logic [NCONST-1:0][EMS-1:0]   requant_const_array_t;
    typedef logic [NCONST-1:0][WI-1:0]    requant_array_t;
    typedef logic [N-1:0][RequantProdWidth-1:0] requant_prod_array_t;

    // Q..OW select sets 0..5; FF shares set 0 with Q.
    function automatic logic [ConstIdxWidth-1:0] const_idx(step_e step);
        logic [ConstIdxWidth-1:0] idx;
        idx = '0;
        if (step != Idle && step != FF) begin
            idx = ConstIdxWidth'(step) - ConstIdxWidth'(1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ita_requant_stage_if.sv
// Beat stream in (accumulator side) and out (output FIFO side) of the requantiser.
interface ita_requant_stage_if
    import ita_requant_stage_pkg::*;
;
    logic         in_valid;
    logic         in_ready;
    oup_t         in_data;
    step_e        in_step;
    logic         out_valid;
    logic         out_ready;
    requant_oup_t out_data;

    modport master (
        output in_valid, in_data, in_step, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_step, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ita_requant_lane.sv
// One lane of requantisation: round-half-up arithmetic shift, signed offset,
// then clip to the 8-bit range selected by the mode.
module ita_requant_lane
    import ita_requant_stage_pkg::*;
(
    input  logic signed [RequantProdWidth-1:0] prod,
    input  logic        [EMS-1:0]              shift,
    input  logic signed [WI-1:0]               add,
    input  requant_mode_e                      mode,
    output logic        [WI-1:0]               result
);

    localparam int unsigned SW = RequantSumWidth;

    localparam logic signed [SW-1:0] SMax = SW'(127);
    localparam logic signed [SW-1:0] SMin = SW'(-128);
    localparam logic signed [SW-1:0] UMax = SW'(255);
    localparam logic signed [SW-1:0] UMin = '0;

    logic signed [SW-1:0] prod_ext;
    logic signed [SW-1:0] round_bias;
    logic signed [SW-1:0] rounded;
    logic signed [SW-1:0] sum;

    always_comb begin
        prod_ext   = {prod[RequantProdWidth-1], prod};
        round_bias = '0;
        rounded    = prod_ext;
        // Shifting out every magnitude bit leaves only the sign.
        if (shift >= EMS'(RequantProdWidth)) begin
            rounded = prod[RequantProdWidth-1] ? '1 : '0;
        end else if (shift != '0) begin
            round_bias = SW'(1) << (shift - EMS'(1));
            rounded    = (prod_ext + round_bias) >>> shift;
        end
        sum = rounded + {{(SW-WI){add[WI-1]}}, add};
    end

    always_comb begin
        result = sum[WI-1:0];
        if (mode == Unsigned) begin
            if (sum > UMax) begin
                result = 8'hff;
            end else if (sum < UMin) begin
                result = 8'h00;
            end
        end else begin
            if (sum > SMax) begin
                result = 8'h7f;
            end else if (sum < SMin) begin
                result = 8'h80;
            end
        end
    end

endmodule

// File: rtl/ita_requant_stage.sv
// Elastic two-stage requantiser: S1 multiplies by eps_mult and latches the
// beat's shift/offset, S2 rounds/offsets/clips every lane into out_data.
module ita_requant_stage
    import ita_requant_stage_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  requant_mode_e        mode_i,
    input  requant_const_array_t eps_mult_i,
    input  requant_const_array_t right_shift_i,
    input  requant_array_t       add_i,
    ita_requant_stage_if.slave   bus,
    output logic                 busy_o,
    output logic                 err_o
);

    logic                       s1_valid_reg, s1_valid_next;
    requant_prod_array_t        s1_prod_reg,  s1_prod_next;
    logic [EMS-1:0]             s1_shift_reg, s1_shift_next;
    logic [WI-1:0]              s1_add_reg,   s1_add_next;
    logic                       s2_valid_reg, s2_valid_next;
    requant_oup_t               out_data_reg, out_data_next;
    logic                       err_reg,      err_next;

    logic [ConstIdxWidth-1:0]   const_sel;
    logic [EMS-1:0]             eps_sel;
    requant_prod_array_t        prod_comb;
    requant_oup_t               lane_result;
    logic                       in_ready;
    logic                       accept;
    logic                       beat_is_idle;
    logic                       s1_advance;

    assign const_sel = const_idx(bus.in_step);
    assign eps_sel   = eps_mult_i[const_sel];

    // Operands widened to the product width so the multiply is sign-correct.
    for (genvar gi = 0; gi < N; gi++) begin : g_mult
        assign prod_comb[gi] = RequantProdWidth'($signed(bus.in_data[gi]))
                             * RequantProdWidth'($signed({1'b0, eps_sel}));
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        ita_requant_lane u_lane (
            .prod   ($signed(s1_prod_reg[gi])),
            .shift  (s1_shift_reg),
            .add    ($signed(s1_add_reg)),
            .mode   (mode_i),
            .result (lane_result[gi])
        );
    end

    assign in_ready     = !flush_i && (!s1_valid_reg || !s2_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && in_ready;
    assign beat_is_idle = (bus.in_step == Idle);
    assign s1_advance   = s1_valid_reg && (!s2_valid_reg || bus.out_ready);

    always_comb begin
        s1_valid_next = s1_valid_reg;
        s1_prod_next  = s1_prod_reg;
        s1_shift_next = s1_shift_reg;
        s1_add_next   = s1_add_reg;
        s2_valid_next = s2_valid_reg;
        out_data_next = out_data_reg;
        err_next      = err_reg || (accept && beat_is_idle);

        if (s1_advance) begin
            s1_valid_next = 1'b0;
        end
        // Idle-tagged beats are consumed but never occupy S1.
        if (accept && !beat_is_idle) begin
            s1_valid_next = 1'b1;
            s1_prod_next  = prod_comb;
            s1_shift_next = right_shift_i[const_sel];
            s1_add_next   = add_i[const_sel];
        end

        if (s1_advance) begin
            s2_valid_next = 1'b1;
            out_data_next = lane_result;
        end else if (bus.out_ready) begin
            s2_valid_next = 1'b0;
        end

        if (flush_i) begin
            s1_valid_next = 1'b0;
            s2_valid_next = 1'b0;
            out_data_next = out_data_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg <= 1'b0;
            s1_prod_reg  <= '0;
            s1_shift_reg <= '0;
            s1_add_reg   <= '0;
            s2_valid_reg <= 1'b0;
            out_data_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s1_prod_reg  <= s1_prod_next;
            s1_shift_reg <= s1_shift_next;
            s1_add_reg   <= s1_add_next;
            s2_valid_reg <= s2_valid_next;
            out_data_reg <= out_data_next;
            err_reg      <= err_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign busy_o        = s1_valid_reg || s2_valid_reg;
    assign err_o         = err_reg;

endmodule

// File: tb/tb_ita_requant_stage.sv
// Scoreboard bench for ita_requant_stage: directed corner beats plus random
// traffic, checked against an integer reference model of the requant rule.
module tb_ita_requant_stage;
    import ita_requant_stage_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    requant_mode_e        mode;
    requant_const_array_t eps;
    requant_const_array_t shv;
    requant_array_t       addv;
    logic                 busy;
    logic                 err;

    ita_requant_stage_if bus ();

    ita_requant_stage dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .mode_i        (mode),
        .eps_mult_i    (eps),
        .right_shift_i (shv),
        .add_i         (addv),
        .bus           (bus),
        .busy_o        (busy),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    int           n_out = 0;
    requant_oup_t sb[$];
    bit           stalled = 1'b0;
    requant_oup_t held;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Requant of one value: floor((x*eps + 2^(sh-1)) / 2^sh) + add, clipped.
    function automatic logic [WI-1:0] ref_lane(longint x, int e, int sh, int a, bit uns);
        longint p, r, v, lo, hi;
        p = x * e;
        if (sh == 0)       r = p;
        else if (sh >= 35) r = (p < 0) ? -1 : 0;
        else               r = (p + (longint'(1) << (sh - 1))) >>> sh;  // floor division
        v  = r + a;
        lo = uns ? 0 : -128;
        hi = uns ? 255 : 127;
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return WI'(v);
    endfunction

    function automatic requant_oup_t model(oup_t d, step_e s);
        requant_oup_t r;
        int i;
        i = (s == FF) ? 0 : int'(s) - 1;
        for (int l = 0; l < N; l++) begin
            r[l] = ref_lane(longint'($signed(d[l])), int'(eps[i]), int'(shv[i]),
                            int'($signed(addv[i])), mode == Unsigned);
        end
        return r;
    endfunction

    function automatic oup_t rand_beat(int max_shift);
        oup_t d;
        logic signed [WO-1:0] t;
        for (int l = 0; l < N; l++) begin
            t = WO'($urandom());
            t = t >>> $urandom_range(0, max_shift);
            d[l] = t;
        end
        return d;
    endfunction

    // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
    initial begin
        requant_oup_t exp_d;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", longint'(bus.out_valid), 1);
                    total++;
                    if (bus.out_data !== held) begin
                        bad++;
                        $display("FAIL stall_data: got %h expected %h", bus.out_data, held);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: got %h expected none", bus.out_data);
                    end else begin
                        exp_d = sb.pop_front();
                        if (bus.out_data !== exp_d) begin
                            bad++;
                            $display("FAIL scoreboard: got %h expected %h", bus.out_data, exp_d);
                        end else begin
                            $display("out %0d data=%h", n_out, bus.out_data);
                        end
                    end
                    n_out++;
                end
                stalled = bus.out_valid && !bus.out_ready && !flush;
                held    = bus.out_data;
            end
        end
    end

    // One clock of stimulus: drive after the edge, decide acceptance mid-cycle.
    task automatic cycle(input bit v, input oup_t d, input step_e s, input bit rdy, output bit acc);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_step   = s;
        bus.out_ready = rdy;
        @(negedge clk);
        acc = v && bus.in_ready;
        if (acc && s != Idle) sb.push_back(model(d, s));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, Q, rdy, acc);
    endtask

    task automatic drain(input string tag);
        bit acc;
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 100) begin
            cycle(1'b0, '0, Q, 1'b1, acc);
            k++;
        end
        check({tag, "_drain"}, longint'(sb.size() == 0 && !busy), 1);
    endtask

    // Single beat with out_valid checked at t+1 (low) and t+2 (high).
    task automatic lat_beat(input oup_t d, input step_e s, input string tag, output requant_oup_t got);
        bit acc;
        cycle(1'b1, d, s, 1'b1, acc);
        check({tag, "_acc"}, longint'(acc), 1);
        check({tag, "_t1"}, longint'(bus.out_valid), 0);
        cycle(1'b0, '0, Q, 1'b1, acc);
        check({tag, "_t2"}, longint'(bus.out_valid), 1);
        got = bus.out_data;
        idle_cycles(1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        oup_t         d;
        oup_t         beats[4];
        requant_oup_t got;
        step_e        steps[7];
        bit           acc;
        int           base;
        int           nacc;

        rst_n = 1'b0;
        flush = 1'b0;
        mode  = Signed;
        eps   = '0;
        shv   = '0;
        addv  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_step   = Q;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data == '0), 1);
        check("rst_busy", longint'(busy), 0);
        check("rst_err", longint'(err), 0);
        check("rst_in_ready", longint'(bus.in_ready), 1);

        // Directed corner values, signed and unsigned clipping.
        eps[0] = 8'd3;   shv[0] = 8'd2; addv[0] = 8'd5;
        eps[1] = 8'd255; shv[1] = 8'd0; addv[1] = 8'd0;
        d = '0;
        d[0] = WO'(100);
        d[1] = WO'(-100);
        d[2] = WO'(33554431);
        lat_beat(d, Q, "sq", got);
        check("sq_lane0", longint'($signed(got[0])), 80);
        check("sq_lane1", longint'($signed(got[1])), -70);
        lat_beat(d, K, "sk", got);
        check("sk_lane2", longint'($signed(got[2])), 127);
        mode = Unsigned;
        lat_beat(d, Q, "uq", got);
        check("uq_lane0", longint'(got[0]), 80);
        check("uq_lane1", longint'(got[1]), 0);
        lat_beat(d, K, "uk", got);
        check("uk_lane2", longint'(got[2]), 255);

        // Every step tag back-to-back, distinct offsets per set.
        mode = Signed;
        for (int i = 0; i < NCONST; i++) begin
            eps[i]  = 8'd1;
            shv[i]  = 8'd0;
            addv[i] = WI'(10 * (i + 1));
        end
        steps = '{Q, K, V, QK, AV, OW, FF};
        base  = n_out;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, rand_beat(19), steps[i], 1'b1, acc);
            check("b2b_acc", longint'(acc), 1);
        end
        check("b2b_out_at7", longint'(n_out - base), 5);
        idle_cycles(2, 1'b1);
        check("b2b_out_at9", longint'(n_out - base), 7);
        drain("b2b");

        // Back-pressure: only two beats fit while the output is stalled.
        eps = '{8'd7, 8'd11, 8'd13, 8'd17, 8'd19, 8'd23};
        shv = '{8'd12, 8'd14, 8'd16, 8'd18, 8'd20, 8'd22};
        for (int i = 0; i < 4; i++) beats[i] = rand_beat(8);
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, beats[nacc], Q, 1'b0, acc);
            if (acc) nacc++;
        end
        check("stall_accepts", longint'(nacc), 2);
        check("stall_in_ready", longint'(bus.in_ready), 0);
        for (int c = 0; c < 20 && nacc < 4; c++) begin
            cycle(1'b1, beats[nacc], Q, 1'b1, acc);
            if (acc) nacc++;
        end
        check("stall_all_sent", longint'(nacc), 4);
        drain("stall");

        // Idle-tagged beat is swallowed and flags an error.
        base = n_out;
        cycle(1'b1, rand_beat(10), Idle, 1'b1, acc);
        check("idle_acc", longint'(acc), 1);
        idle_cycles(3, 1'b1);
        check("idle_err", longint'(err), 1);
        check("idle_no_out", longint'(n_out - base), 0);
        check("idle_busy", longint'(busy), 0);

        // Flush with two beats held; the beat offered during flush is refused.
        cycle(1'b1, rand_beat(10), V, 1'b0, acc);
        cycle(1'b1, rand_beat(10), V, 1'b0, acc);
        check("flush_busy_before", longint'(busy), 1);
        flush = 1'b1;
        cycle(1'b1, rand_beat(10), V, 1'b0, acc);
        flush = 1'b0;
        check("flush_acc", longint'(acc), 0);
        check("flush_busy_after", longint'(busy), 0);
        check("flush_out_valid", longint'(bus.out_valid), 0);
        while (sb.size() > 0) void'(sb.pop_back());
        base = n_out;
        idle_cycles(3, 1'b1);
        check("flush_no_out", longint'(n_out - base), 0);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(10), QK, 1'b1, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", longint'(bus.out_valid), 0);
        check("arst_busy", longint'(busy), 0);
        check("arst_err", longint'(err), 0);
        sb.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat_beat(rand_beat(10), AV, "post_rst", got);
        drain("post_rst");

        // Random traffic with random back-pressure, constants refreshed while idle.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < NCONST; i++) begin
                eps[i]  = EMS'($urandom_range(0, 255));
                shv[i]  = EMS'($urandom_range(8, 30));
                addv[i] = WI'($urandom());
            end
            shv[4] = 8'd0;
            shv[5] = EMS'($urandom_range(34, 40));
            mode   = (ph % 2 == 0) ? Signed : Unsigned;
            for (int c = 0; c < 150; c++) begin
                cycle($urandom_range(0, 3) != 0, rand_beat(24), step_e'($urandom_range(0, 7)),
                      $urandom_range(0, 3) != 0, acc);
            end
            drain("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
